// File: rtl/gomoku_kb_pkg.sv
// Shared keypad definitions: FSM states, idle row value, code field layout.
// Used by keypad_scanner and by the game controller for x/y entry.
package gomoku_kb_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } kb_state_e;

    localparam logic [3:0] KEY_NONE = 4'b1111;

    localparam int KEY_ROW_MSB = 3;
    localparam int KEY_ROW_LSB = 2;
    localparam int KEY_COL_MSB = 1;
    localparam int KEY_COL_LSB = 0;

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        logic [3:0] d;
        d = 4'b1111;
        d[2'd3 - c] = 1'b0;
        return d;
    endfunction

    // Lowest row index wins, i.e. bit 3 has top priority.
    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] r;
        r = 2'd3;
        if (!rows[3])
            r = 2'd0;
        else if (!rows[2])
            r = 2'd1;
        else if (!rows[1])
            r = 2'd2;
        return r;
    endfunction

    function automatic logic [3:0] make_code(input logic [1:0] r,
                                             input logic [1:0] c);
        logic [3:0] k;
        k = '0;
        k[KEY_ROW_MSB:KEY_ROW_LSB] = r;
        k[KEY_COL_MSB:KEY_COL_LSB] = c;
        return k;
    endfunction

endpackage

// File: rtl/kb_scan_tick.sv
// Scan-tick prescaler: one-clk tick every SCAN_DIV clks while enabled.
// Disabling clears the count so the next enable starts a fresh period.
module kb_scan_tick #(
    parameter int SCAN_DIV = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] pcnt;

    always_ff @(posedge clk) begin
        if (rst || !en)
            pcnt <= '0;
        else if (pcnt == LAST)
            pcnt <= '0;
        else
            pcnt <= pcnt + PW'(1);
    end

    assign tick = en && !rst && (pcnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce; one key_valid per press.
// Define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid every REPEAT_TICKS while held.
module keypad_scanner
    import gomoku_kb_pkg::*;
#(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_TICKS   = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_en,
    input  logic [3:0] keyboard_row,
    output logic [3:0] keyboard_col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_down
);

    localparam int CNT_MAX = (DEBOUNCE_TICKS > REPEAT_TICKS) ?
                             DEBOUNCE_TICKS : REPEAT_TICKS;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS);

    logic [3:0] row_s1, row_s2;
    logic       tick;

    kb_state_e   state_q, state_d;
    logic [1:0]  col_q, col_d;
    logic [1:0]  cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        down_q, down_d;
    logic [3:0]  code_q, code_d;
    logic        valid;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_TICKS);
    logic [CW-1:0] rep_q, rep_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1 <= KEY_NONE;
            row_s2 <= KEY_NONE;
        end else begin
            row_s1 <= keyboard_row;
            row_s2 <= row_s1;
        end
    end

    kb_scan_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (scan_en),
        .tick (tick)
    );

    logic          hit;
    logic          same;
    logic [1:0]    srow;
    logic [CW-1:0] cnt_inc;

    assign hit     = (row_s2 != KEY_NONE);
    assign srow    = row_index(row_s2);
    assign same    = hit && (srow == cand_q);
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        down_d  = down_q;
        code_d  = code_q;
        valid   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif
        if (!scan_en) begin
            state_d = ST_SCAN;
            col_d   = 2'd0;
            cnt_d   = '0;
            down_d  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d   = '0;
`endif
        end else if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (hit) begin
                        cand_d  = srow;
                        cnt_d   = CW'(1);
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (same) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_LAST) begin
                            valid   = 1'b1;
                            code_d  = make_code(cand_q, col_q);
                            down_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d   = '0;
`endif
                        end
                    end else begin
                        state_d = ST_SCAN;
                        col_d   = col_q + 2'd1;
                        cnt_d   = '0;
                    end
                end
                ST_HELD: begin
                    if (!hit) begin
                        cnt_d   = CW'(1);
                        state_d = ST_RELEASE;
                    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rep_q + CW'(1) == RP_LAST) begin
                            valid  = 1'b1;
                            code_d = make_code(cand_q, col_q);
                            rep_d  = '0;
                        end else begin
                            rep_d = rep_q + CW'(1);
                        end
`endif
                    end
                end
                ST_RELEASE: begin
                    if (!hit) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_LAST) begin
                            down_d  = 1'b0;
                            cnt_d   = '0;
                            col_d   = col_q + 2'd1;
                            state_d = ST_SCAN;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_HELD;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SCAN;
            col_q   <= 2'd0;
            cand_q  <= 2'd0;
            cnt_q   <= '0;
            down_q  <= 1'b0;
            code_q  <= 4'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            down_q  <= down_d;
            code_q  <= code_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    // key_valid shares the tick clk, so the code is presented alongside it
    assign key_valid    = valid;
    assign key_code     = valid ? make_code(cand_q, col_q) : code_q;
    assign key_down     = down_q;
    assign keyboard_col = scan_en ? col_drive(col_q) : 4'b1111;

endmodule
